// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared types and sizing helpers for the carry-save resolver
// Holds the resolver state encoding and the chunk-count / index-width helpers
// used by csa_resolve to size its sequencing logic. No ports.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

    // Number of CHUNK-bit slices in a WIDTH-bit operand.
    function automatic int csa_num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index register width; one spare bit so the count never wraps to zero.
    function automatic int csa_idx_width(input int width, input int chunk);
        return $clog2(width / chunk) + 1;
    endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// rtl/csa_chunk_add.sv - combinational CHUNK-bit ripple-carry adder slice
// Ports:
//   a, b  [CHUNK-1:0]  addend slices
//   cin               carry into bit 0
//   s     [CHUNK-1:0]  sum slice
//   cout              carry out of the top bit
module csa_chunk_add #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[CHUNK];
    end

endmodule

// File: rtl/csa_resolve.sv
// rtl/csa_resolve.sv - multi-cycle carry-propagate resolver for (sum, carry) pairs
// Adds a redundant pair CHUNK bits per clock with a registered inter-chunk carry.
// Optional build macro: CSA_RESOLVE_EARLY_EN (finish as soon as nothing is left to add).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       operand handshake (in_ready = state is IDLE)
//   in_sum, in_carry [WIDTH]  redundant operand pair
//   out_valid / out_ready     result handshake
//   out_result [WIDTH+1]      binary sum, MSB is the final carry-out
module csa_resolve
    import csa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_result
);

    localparam int N  = csa_num_chunks(WIDTH, CHUNK);
    localparam int IW = csa_idx_width(WIDTH, CHUNK);

    csa_state_e       state_q, state_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] car_sr_q, car_sr_d;
    logic             cin_q, cin_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] chunk_s;
    logic             chunk_cout;
    logic             last_chunk;
    logic             finish;

    csa_chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a    (sum_sr_q[CHUNK-1:0]),
        .b    (car_sr_q[CHUNK-1:0]),
        .cin  (cin_q),
        .s    (chunk_s),
        .cout (chunk_cout)
    );

    assign last_chunk = (idx_q == IW'(N - 1));

`ifdef CSA_RESOLVE_EARLY_EN
    // Nothing left above this chunk and no carry to push into it: the
    // remaining result bits are already zero from the clear at acceptance.
    logic rest_zero;
    assign rest_zero = ((sum_sr_q >> CHUNK) == '0) && ((car_sr_q >> CHUNK) == '0) && !chunk_cout;
    assign finish    = last_chunk || rest_zero;
`else
    assign finish    = last_chunk;
`endif

    always_comb begin
        state_d     = state_q;
        sum_sr_d    = sum_sr_q;
        car_sr_d    = car_sr_q;
        cin_d       = cin_q;
        idx_d       = idx_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sum_sr_d = in_sum;
                    car_sr_d = in_carry;
                    cin_d    = 1'b0;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Constant-indexed slice write keeps the result mux small and lint-clean.
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IW'(i)) begin
                        result_d[i*CHUNK +: CHUNK] = chunk_s;
                    end
                end
                cin_d    = chunk_cout;
                sum_sr_d = sum_sr_q >> CHUNK;
                car_sr_d = car_sr_q >> CHUNK;
                idx_d    = idx_q + IW'(1);
                if (finish) begin
                    // On early exit chunk_cout is 0, so this is still correct.
                    result_d[WIDTH] = chunk_cout;
                    out_valid_d     = 1'b1;
                    state_d         = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sum_sr_q    <= '0;
            car_sr_q    <= '0;
            cin_q       <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_sr_q    <= sum_sr_d;
            car_sr_q    <= car_sr_d;
            cin_q       <= cin_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = result_q;

endmodule

// File: tb/tb_csa_resolve.sv
// tb/tb_csa_resolve.sv - self-checking bench for csa_resolve (WIDTH=8, CHUNK=2)
module tb_csa_resolve;

    localparam int N = 4;
`ifdef CSA_RESOLVE_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_sum;
    logic [7:0] in_carry;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_result;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        logic [8:0] res;
        int         lat_fixed;
        int         lat_early;
    } vec_t;

    vec_t vecs[9];

    csa_resolve #(.WIDTH(8), .CHUNK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input string name);
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got result %0h with empty scoreboard expected none", name, out_result);
        end else begin
            e = exp_q.pop_front();
            chk(name, 32'(out_result), 32'(e));
        end
    endtask

    // Drive one pair, wait for out_valid, compare latency and result.
    // Returns right after out_valid is seen (handshake not yet taken if out_ready=0).
    task automatic run_pair(input logic [7:0] s, input logic [7:0] c,
                            input logic [8:0] res, input int lat);
        int waited;
        int cyc;
        @(negedge clk);
        in_sum   = s;
        in_carry = c;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(res);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("latency", 32'(cyc), 32'(lat));
        pop_cmp("result");
    endtask

    initial begin
        logic [7:0] rs, rc;
        int sent, got, prev_acc;
        bit acc;

        vecs[0] = '{8'h0A, 8'h14, 9'h01E, 4, 3};
        vecs[1] = '{8'hFF, 8'hFF, 9'h1FE, 4, 4};
        vecs[2] = '{8'h00, 8'h00, 9'h000, 4, 1};
        vecs[3] = '{8'h03, 8'h01, 9'h004, 4, 2};
        vecs[4] = '{8'h80, 8'h80, 9'h100, 4, 4};
        vecs[5] = '{8'h01, 8'h01, 9'h002, 4, 1};
        vecs[6] = '{8'h55, 8'hAA, 9'h0FF, 4, 4};
        vecs[7] = '{8'hFF, 8'h01, 9'h100, 4, 4};
        vecs[8] = '{8'h64, 8'h64, 9'h0C8, 4, 4};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_result", 32'(out_result), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Table-driven vectors with immediate consumption.
        for (int i = 0; i < 9; i++) begin
            run_pair(vecs[i].s, vecs[i].c, vecs[i].res,
                     EARLY ? vecs[i].lat_early : vecs[i].lat_fixed);
            @(posedge clk);
            #1;
            chk("post_hs_in_ready", 32'(in_ready), 32'd1);
            chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        end

        // Backpressure: hold result, ignore a second in_valid.
        out_ready = 1'b0;
        run_pair(8'h64, 8'h64, 9'h0C8, 4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sum   = 8'h11;
            in_carry = 8'h11;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_result", 32'(out_result), 32'h0C8);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_hs_in_ready", 32'(in_ready), 32'd1);
        chk("bp_hs_out_valid", 32'(out_valid), 32'd0);
        chk("bp_hs_result_held", 32'(out_result), 32'h0C8);

        // Reset two cycles into RUN discards the transaction immediately.
        @(negedge clk);
        in_sum   = 8'h55;
        in_carry = 8'hAA;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_run_out_valid", 32'(out_valid), 32'd0);
        chk("rst_run_out_result", 32'(out_result), 32'd0);
        chk("rst_run_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_pair(8'h01, 8'h01, 9'h002, EARLY ? 1 : 4);

        // Streaming: in_valid held high, out_ready=1, 10 random pairs.
        @(posedge clk);
        #1;
        rs       = 8'($urandom);
        rc       = 8'($urandom);
        in_sum   = rs;
        in_carry = rc;
        in_valid = 1'b1;
        sent     = 0;
        got      = 0;
        prev_acc = -1;
        for (int cyc = 0; cyc < 500 && got < 10; cyc++) begin
            @(negedge clk);
            acc = in_ready && in_valid;
            if (out_valid) begin
                pop_cmp("stream_result");
                got++;
            end
            if (acc) begin
                exp_q.push_back({1'b0, in_sum} + {1'b0, in_carry});
`ifndef CSA_RESOLVE_EARLY_EN
                if (prev_acc >= 0) chk("stream_spacing", 32'(cyc - prev_acc), 32'(N + 2));
`endif
                prev_acc = cyc;
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (sent < 10) begin
                    in_sum   = 8'($urandom);
                    in_carry = 8'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("stream_count", 32'(got), 32'd10);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
